// File: rtl/tpu_seq.sv
// tpu_seq: sequencer for an N x N weight-stationary systolic array.
//
// It loads N*N weights, streams N input rows with per-step enables, drains
// the array for N+1 further steps, captures the skewed column outputs into a
// result buffer, and unloads the buffer one result per beat.
//
// Ports
//   clk, rst           clock (posedge), synchronous active-high reset
//   start, reuse_w     begin a job (sampled in IDLE); reuse_w=1 skips LOADW
//   w_valid/w_ready    weight beats, w_data = weight[widx], row-major
//   x_valid/x_ready    input rows, lane j at x_data[j*DW +: DW]
//   r_valid/r_ready    result beats, r_data = res[ridx]
//   sa_clr, sa_en      array accumulator clear and step enable
//   sa_w, sa_in        weight bus and row bus to the array
//   sa_out             array column outputs, column j at [j*AW +: AW]
//   busy, done         busy outside IDLE; done pulses on entering IDLE
//                      after the last result is accepted
//   fsm_state          current FSM state (debug visibility)
//
// Handshakes: a beat transfers on a rising clk edge where valid and ready
// are both high. The sequencer's own ready/valid outputs are functions of
// state and counters only and never depend on the opposite valid/ready in
// the same cycle; a driven valid is held with stable data until accepted.

module tpu_seq #(
  parameter int N  = 3,
  parameter int DW = 8,
  parameter int AW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              reuse_w,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DW-1:0]     w_data,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic [N*DW-1:0]   x_data,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [AW-1:0]     r_data,
  output logic              sa_clr,
  output logic              sa_en,
  output logic [N*N*DW-1:0] sa_w,
  output logic [N*DW-1:0]   sa_in,
  input  logic [N*AW-1:0]   sa_out,
  output logic              busy,
  output logic              done,
  output logic [2:0]        fsm_state
);

  localparam int NN = N * N;
  localparam int IW = $clog2(NN);
  // t counts 0..2N and may step once past 2N on the final firing step.
  localparam int TW = $clog2(2 * N + 2);

  localparam logic [IW-1:0] IDX_LAST = IW'(NN - 1);
  localparam logic [TW-1:0] T_DRAIN  = TW'(N);
  localparam logic [TW-1:0] T_LAST   = TW'(2 * N);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOADW  = 3'd1,
    S_CLR    = 3'd2,
    S_RUN    = 3'd3,
    S_UNLOAD = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [IW-1:0]      widx;
  logic [IW-1:0]      ridx;
  logic [TW-1:0]      t;
  logic [N*N*DW-1:0]  w_reg;
  logic [AW-1:0]      res [NN];
  logic               done_q;

  logic w_fire;
  logic r_fire;
  logic step;
  logic drain;

  // Next state and control outputs.
  always_comb begin
    state_nxt = state;
    w_ready   = 1'b0;
    x_ready   = 1'b0;
    r_valid   = 1'b0;
    sa_clr    = 1'b0;
    sa_en     = 1'b0;
    sa_in     = '0;
    r_data    = '0;
    step      = 1'b0;
    drain     = (t >= T_DRAIN);
    w_fire    = 1'b0;
    r_fire    = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) state_nxt = reuse_w ? S_CLR : S_LOADW;
      end
      S_LOADW: begin
        w_ready = 1'b1;
        w_fire  = w_valid;
        if (w_fire && widx == IDX_LAST) state_nxt = S_CLR;
      end
      S_CLR: begin
        sa_clr    = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        // Feed phase steps only when a row arrives; drain phase free-runs.
        x_ready = !drain;
        step    = drain || x_valid;
        sa_en   = step;
        if (!drain && x_valid) sa_in = x_data;
        if (step && t == T_LAST) state_nxt = S_UNLOAD;
      end
      S_UNLOAD: begin
        r_valid = 1'b1;
        r_data  = res[ridx];
        r_fire  = r_ready;
        if (r_fire && ridx == IDX_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      widx   <= '0;
      ridx   <= '0;
      t      <= '0;
      w_reg  <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < NN; i++) res[i] <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= r_fire && (ridx == IDX_LAST);

      if (state == S_IDLE) widx <= '0;

      if (w_fire) begin
        w_reg[int'(widx) * DW +: DW] <= w_data;
        widx <= widx + 1'b1;
      end

      if (state == S_CLR) begin
        t    <= '0;
        ridx <= '0;
      end

      if (step) begin
        t <= t + 1'b1;
        // Column j's outputs emerge skewed by j+1 steps; output k of column
        // j appears at step t = j+1+k.
        for (int j = 0; j < N; j++) begin
          if (int'(t) >= j + 1 && int'(t) <= j + N)
            res[IW'(j * N + int'(t) - j - 1)] <= sa_out[j * AW +: AW];
        end
      end

      if (r_fire) ridx <= ridx + 1'b1;
    end
  end

  assign sa_w      = w_reg;
  assign busy      = (state != S_IDLE);
  assign done      = done_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_tpu_seq.sv
// tb_tpu_seq: directed self-checking bench for tpu_seq.
//
// A stub array drives sa_out[j] = 0x100*j + step, where step counts sa_en
// cycles since the last sa_clr, so captured results reveal exactly which
// step each buffer entry was taken from.

module tb_tpu_seq;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int AW = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOADW  = 3'd1;
  localparam logic [2:0] ST_CLR    = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_UNLOAD = 3'd4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              reuse_w = 1'b0;
  logic              w_valid = 1'b0;
  logic              w_ready;
  logic [DW-1:0]     w_data = '0;
  logic              x_valid = 1'b0;
  logic              x_ready;
  logic [N*DW-1:0]   x_data = '0;
  logic              r_valid;
  logic              r_ready = 1'b0;
  logic [AW-1:0]     r_data;
  logic              sa_clr;
  logic              sa_en;
  logic [N*N*DW-1:0] sa_w;
  logic [N*DW-1:0]   sa_in;
  logic [N*AW-1:0]   sa_out;
  logic              busy;
  logic              done;
  logic [2:0]        fsm_state;

  int                n_checks = 0;
  int                n_fail = 0;
  int                stub_t = 0;
  logic [AW-1:0]     exp_q[$];
  logic [N*N*DW-1:0] exp_w;

  tpu_seq #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .reuse_w(reuse_w),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .sa_clr(sa_clr), .sa_en(sa_en), .sa_w(sa_w), .sa_in(sa_in),
    .sa_out(sa_out), .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Stub array
  always @(posedge clk) begin
    if (rst || sa_clr) stub_t <= 0;
    else if (sa_en)    stub_t <= stub_t + 1;
  end

  always_comb begin
    sa_out = '0;
    for (int j = 0; j < N; j++) sa_out[j*AW +: AW] = AW'(256 * j + stub_t);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] row_val(input int r);
    logic [N*DW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = DW'(r * N + j + 1);
    return v;
  endfunction

  task automatic check_reset_outs(input string pfx);
    check({pfx, " busy"},    busy, 0);
    check({pfx, " done"},    done, 0);
    check({pfx, " w_ready"}, w_ready, 0);
    check({pfx, " x_ready"}, x_ready, 0);
    check({pfx, " r_valid"}, r_valid, 0);
    check({pfx, " sa_en"},   sa_en, 0);
    check({pfx, " sa_clr"},  sa_clr, 0);
    check({pfx, " sa_in"},   sa_in, 0);
    check({pfx, " r_data"},  r_data, 0);
    check({pfx, " sa_w"},    sa_w, 0);
    check({pfx, " state"},   fsm_state, ST_IDLE);
  endtask

  // Driver: called at a negedge in LOADW; returns at the negedge in CLR.
  task automatic load_weights();
    for (int i = 0; i < N * N; i++) begin
      w_valid = 1'b1;
      w_data  = DW'(i + 1);
      @(negedge clk);
      if (i % 3 == 1) begin
        w_valid = 1'b0;
        #1;
        check("w_ready in gap", w_ready, 1);
        @(negedge clk);
      end
    end
    w_valid = 1'b0;
    #1;
    check("w_ready after last", w_ready, 0);
    check("sa_clr after load", sa_clr, 1);
    check("state after load", fsm_state, ST_CLR);
  endtask

  // Driver: called at the negedge in CLR; returns at the negedge in UNLOAD.
  task automatic run_rows(input int stall);
    @(negedge clk);
    check("sa_clr width", sa_clr, 0);
    check("state run", fsm_state, ST_RUN);
    for (int r = 0; r < N; r++) begin
      if (r == 2) begin
        for (int s = 0; s < stall; s++) begin
          x_valid = 1'b0;
          #1;
          check("stall sa_en", sa_en, 0);
          check("stall x_ready", x_ready, 1);
          @(negedge clk);
        end
      end
      x_valid = 1'b1;
      x_data  = row_val(r);
      #1;
      check("feed x_ready", x_ready, 1);
      check("feed sa_en", sa_en, 1);
      check("feed sa_in", sa_in, row_val(r));
      @(negedge clk);
    end
    x_valid = 1'b0;
    x_data  = '0;
    for (int d = 0; d <= N; d++) begin
      #1;
      check("drain sa_en", sa_en, 1);
      check("drain x_ready", x_ready, 0);
      check("drain sa_in", sa_in, 0);
      @(negedge clk);
    end
    check("r_valid after drain", r_valid, 1);
    check("state unload", fsm_state, ST_UNLOAD);
  endtask

  // Scoreboard-driven unload; returns at the negedge of the done cycle.
  task automatic unload(input bit toggle);
    int guard;
    bit rr;
    exp_q = '{16'h001, 16'h002, 16'h003, 16'h102, 16'h103, 16'h104,
              16'h203, 16'h204, 16'h205};
    guard = 0;
    rr = !toggle;
    while (exp_q.size() > 0 && guard < 40) begin
      r_ready = rr;
      #1;
      check("unload r_valid", r_valid, 1);
      check("unload r_data", r_data, exp_q[0]);
      check("unload done low", done, 0);
      if (rr) void'(exp_q.pop_front());
      @(negedge clk);
      guard++;
      if (toggle) rr = !rr;
    end
    r_ready = 1'b0;
    check("unload budget", exp_q.size(), 0);
    check("done pulse", done, 1);
    check("busy after unload", busy, 0);
    check("state after unload", fsm_state, ST_IDLE);
    check("r_valid after unload", r_valid, 0);
  endtask

  initial begin
    int cyc;
    for (int k = 0; k < N * N; k++) exp_w[k*DW +: DW] = DW'(k + 1);

    // Reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outs("idle");

    // Job A: weight load with gaps, unstalled rows, free unload
    start = 1'b1;
    reuse_w = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("A busy", busy, 1);
    check("A w_ready", w_ready, 1);
    check("A state", fsm_state, ST_LOADW);
    check("A sa_clr", sa_clr, 0);
    load_weights();
    check("A sa_w", sa_w, exp_w);
    run_rows(0);
    unload(1'b0);

    // Job B: started in the done cycle, weight reuse, input stall, backpressure
    start = 1'b1;
    reuse_w = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reuse_w = 1'b0;
    check("B sa_clr", sa_clr, 1);
    check("B w_ready", w_ready, 0);
    check("B done low", done, 0);
    check("B busy", busy, 1);
    check("B state", fsm_state, ST_CLR);
    check("B sa_w kept", sa_w, exp_w);
    run_rows(4);
    unload(1'b1);

    // Job C: latency to first r_valid, r_ready held high throughout
    @(negedge clk);
    check("done width", done, 0);
    r_ready = 1'b1;
    x_valid = 1'b1;
    x_data  = row_val(0);
    start = 1'b1;
    reuse_w = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reuse_w = 1'b0;
    cyc = 0;
    while (!r_valid && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    x_valid = 1'b0;
    check("C first r_valid latency", cyc, 2 * N + 2);
    unload(1'b0);
    check("C sa_w kept", sa_w, exp_w);

    // Job D: reset in the middle of RUN
    @(negedge clk);
    start = 1'b1;
    reuse_w = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reuse_w = 1'b0;
    @(negedge clk);
    x_valid = 1'b1;
    x_data  = row_val(1);
    @(negedge clk);
    check("D state before rst", fsm_state, ST_RUN);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_reset_outs("mid-run reset");
    end
    rst = 1'b0;
    x_valid = 1'b0;
    @(negedge clk);
    check_reset_outs("after mid-run reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
